uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- Responder end of the host UART link. It consumes bytes from the uart_rx byte interface, parses 'W'/'R' register commands, and updates or reads a local register bank.
- Each reply is sent through the uart_tx byte interface, with handshakes on busy and done.
- Sits between the UART RX/TX pair and the design's control registers.

Parameters:
NUM_REGS, 16, number of 8-bit registers; ADDR_W = clog2(NUM_REGS) (local, minimum 1)
TIMEOUT_CLKS, 17360, max clocks between bytes of one command (4 byte times at 434 clks/bit) before the command is abandoned

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_rx_byte_rdy  input  1  one-cycle strobe, i_rx_byte valid
i_rx_byte  input  8  received byte
o_tx_byte_rdy  output  1  one-cycle strobe requesting transmission of o_tx_byte
o_tx_byte  output  8  byte to transmit, held stable from strobe until i_tx_done
i_tx_busy  input  1  transmitter busy
i_tx_done  input  1  one-cycle strobe, transmission complete
o_reg_wr  output  1  one-cycle strobe on a register write
o_reg_addr  output  ADDR_W  address of last write
o_reg_wdata  output  8  data of last write
o_regs  output  NUM_REGS*8  flat register bank, reg k at bits [8k+7:8k]
o_busy  output  1  high in every state except IDLE
o_err  output  1  one-cycle strobe: bad command, bad address or timeout

Behaviour:
- Reset (async assert, sync release): state IDLE. All registers, o_tx_byte, o_reg_addr and o_reg_wdata are 0x00. All strobes are 0, o_busy=0, timeout counter 0.
- Frames:
  - Write: 0x57 'W', addr, data. Reply is 0x4B 'K'.
  - Read: 0x52 'R', addr. Reply is the register value.
  - Address check: addr >= NUM_REGS gives reply 0x45 'E' and no write. The address compare uses the full 8 bits.
  - Any other first byte gives reply 0x3F '?' and o_err.
- States:
  - IDLE: on rx strobe go to GET_ADDR ('W'/'R'; latch opcode) or SEND with '?'.
  - GET_ADDR: on rx strobe latch addr. A 'R' goes to SEND; a 'W' goes to GET_DATA.
  - GET_DATA: on rx strobe go to SEND.
  - SEND: wait until i_tx_busy=0. Then pulse o_tx_byte_rdy for exactly one cycle and go to WAIT_TX.
  - WAIT_TX: on i_tx_done go to IDLE (or to a second SEND if the checksum feature is enabled).
- Write commit timing:
  - The register updates on the clock edge that accepts the data byte.
  - o_reg_wr pulses in the cycle after that edge, with o_reg_addr and o_reg_wdata valid.
  - o_regs reflects the new value in the same cycle as that o_reg_wr pulse.
- Read reply value: the register value at the cycle the addr byte is accepted.
- Latency: o_tx_byte_rdy is asserted 1 cycle after the final command byte strobe when i_tx_busy=0; otherwise on the first cycle after i_tx_busy falls.
- Timeout:
  - The counter runs only in GET_ADDR and GET_DATA and reloads on every rx strobe.
  - On reaching TIMEOUT_CLKS-1 the block goes to IDLE, pulses o_err, sends no reply and writes nothing.
  - If an rx strobe arrives in the same cycle as expiry, the byte wins and the command continues.
- Bytes strobed in SEND or WAIT_TX are dropped silently; no queueing.
- A spurious i_tx_done outside WAIT_TX is ignored.
- Reset mid-transmission: outputs return to reset values immediately. A byte already handed to uart_tx is not recalled.

Optional Feature:
- RESP_CHECKSUM_EN defined: every reply is followed by a second byte equal to reply XOR 0xFF. It uses the same SEND/WAIT_TX handshake, and o_busy stays high until the second i_tx_done.
- Undefined: single-byte replies only, with no extra state or logic.

Test Plan:
- Write then read: rx 0x57,0x03,0xA5 -> o_reg_wr pulse with addr 3 and data 0xA5, reply 0x4B, o_regs[31:24]=0xA5. Then rx 0x52,0x03 -> reply 0xA5.
- Bad address: rx 0x57,0x10,0x11 with NUM_REGS=16 -> reply 0x45, no o_reg_wr, all registers unchanged.
- Bad opcode: rx 0x41 -> o_err pulse, reply 0x3F, back to IDLE.
- Inter-byte timeout: rx 0x57,0x02, then silence for TIMEOUT_CLKS -> o_err pulse, no reply. Next rx 0x52,0x02 -> reply 0x00.
- Busy handshake: hold i_tx_busy=1 while the final byte arrives -> no o_tx_byte_rdy until busy drops, then exactly one strobe. Bytes sent during WAIT_TX are dropped.
- With RESP_CHECKSUM_EN: read of a register holding 0x5A -> replies 0x5A then 0xA5. Also assert reset mid-frame -> all outputs return to 0.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// UART command responder: parses 'W'/'R' byte commands into a local register bank and replies via uart_tx.
// Optional RESP_CHECKSUM_EN: each reply byte is followed by its bitwise complement.
module uart_cmd_responder #(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned TIMEOUT_CLKS = 17360,
  localparam int unsigned ADDR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_byte_rdy,
  input  logic [7:0]            i_rx_byte,
  output logic                  o_tx_byte_rdy,
  output logic [7:0]            o_tx_byte,
  input  logic                  i_tx_busy,
  input  logic                  i_tx_done,
  output logic                  o_reg_wr,
  output logic [ADDR_W-1:0]     o_reg_addr,
  output logic [7:0]            o_reg_wdata,
  output logic [NUM_REGS*8-1:0] o_regs,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int unsigned TMR_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_BADAD = 8'h45;
  localparam logic [7:0] RSP_BADOP = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_SEND,
    S_WAIT_TX
  } state_e;

  state_e              state_q, state_d;
  logic                is_wr_q, is_wr_d;
  logic [7:0]          addr_q, addr_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_rdy_q, tx_rdy_d;
  logic                err_q, err_d;
  logic                reg_wr_q, reg_wr_d;
  logic [ADDR_W-1:0]   reg_addr_q, reg_addr_d;
  logic [7:0]          reg_wdata_q, reg_wdata_d;
  logic                busy_q, busy_d;
  logic [7:0]          regs_q [NUM_REGS];
  logic [7:0]          regs_d [NUM_REGS];
`ifdef RESP_CHECKSUM_EN
  logic                second_q, second_d;
`endif

  logic                launch;
  logic [7:0]          reply;
  logic                rx_ok, addr_ok, tmr_expired;
  logic [ADDR_W-1:0]   rx_idx, addr_idx;

  assign rx_ok       = 32'(i_rx_byte) < NUM_REGS;
  assign addr_ok     = 32'(addr_q) < NUM_REGS;
  assign rx_idx      = ADDR_W'(i_rx_byte);
  assign addr_idx    = ADDR_W'(addr_q);
  assign tmr_expired = (timer_q == TMR_W'(TIMEOUT_CLKS - 1));

  // State register and all registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      timer_q     <= '0;
      tx_byte_q   <= '0;
      tx_rdy_q    <= 1'b0;
      err_q       <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      busy_q      <= 1'b0;
      for (int k = 0; k < int'(NUM_REGS); k++) regs_q[k] <= '0;
`ifdef RESP_CHECKSUM_EN
      second_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      timer_q     <= timer_d;
      tx_byte_q   <= tx_byte_d;
      tx_rdy_q    <= tx_rdy_d;
      err_q       <= err_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      busy_q      <= busy_d;
      for (int k = 0; k < int'(NUM_REGS); k++) regs_q[k] <= regs_d[k];
`ifdef RESP_CHECKSUM_EN
      second_q    <= second_d;
`endif
    end
  end

  // Command parser, reply launcher and transmit handshake
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    timer_d     = timer_q;
    tx_byte_d   = tx_byte_q;
    tx_rdy_d    = 1'b0;
    err_d       = 1'b0;
    reg_wr_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    regs_d      = regs_q;
    launch      = 1'b0;
    reply       = 8'h00;
`ifdef RESP_CHECKSUM_EN
    second_d    = second_q;
`endif

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (i_rx_byte_rdy) begin
          if (i_rx_byte == OP_WRITE || i_rx_byte == OP_READ) begin
            is_wr_d = (i_rx_byte == OP_WRITE);
            state_d = S_GET_ADDR;
          end else begin
            launch = 1'b1;
            reply  = RSP_BADOP;
            err_d  = 1'b1;
          end
        end
      end

      S_GET_ADDR: begin
        if (i_rx_byte_rdy) begin
          timer_d = '0;
          addr_d  = i_rx_byte;
          if (is_wr_q) begin
            state_d = S_GET_DATA;
          end else begin
            launch = 1'b1;
            reply  = rx_ok ? regs_q[rx_idx] : RSP_BADAD;
            err_d  = !rx_ok;
          end
        end else if (tmr_expired) begin
          state_d = S_IDLE;
          timer_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_GET_DATA: begin
        if (i_rx_byte_rdy) begin
          timer_d = '0;
          launch  = 1'b1;
          if (addr_ok) begin
            regs_d[addr_idx] = i_rx_byte;
            reg_wr_d         = 1'b1;
            reg_addr_d       = addr_idx;
            reg_wdata_d      = i_rx_byte;
            reply            = RSP_OK;
          end else begin
            reply = RSP_BADAD;
            err_d = 1'b1;
          end
        end else if (tmr_expired) begin
          state_d = S_IDLE;
          timer_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_SEND: begin
        if (!i_tx_busy) begin
          tx_rdy_d = 1'b1;
          state_d  = S_WAIT_TX;
        end
      end

      S_WAIT_TX: begin
        if (i_tx_done) begin
`ifdef RESP_CHECKSUM_EN
          if (!second_q) begin
            second_d  = 1'b1;
            tx_byte_d = tx_byte_q ^ 8'hFF;
            state_d   = S_SEND;
          end else begin
            second_d  = 1'b0;
            state_d   = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Final command byte: strobe immediately when the transmitter is free
    if (launch) begin
      tx_byte_d = reply;
`ifdef RESP_CHECKSUM_EN
      second_d  = 1'b0;
`endif
      if (!i_tx_busy) begin
        tx_rdy_d = 1'b1;
        state_d  = S_WAIT_TX;
      end else begin
        state_d  = S_SEND;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_out
    assign o_regs[8*g +: 8] = regs_q[g];
  end

  assign o_tx_byte_rdy = tx_rdy_q;
  assign o_tx_byte     = tx_byte_q;
  assign o_reg_wr      = reg_wr_q;
  assign o_reg_addr    = reg_addr_q;
  assign o_reg_wdata   = reg_wdata_q;
  assign o_busy        = busy_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: scoreboard of expected reply bytes plus a register model.
module tb_uart_cmd_responder;

  localparam int unsigned NUM_REGS     = 16;
  localparam int unsigned TIMEOUT_CLKS = 17360;
  localparam int unsigned ADDR_W       = 4;
`ifdef RESP_CHECKSUM_EN
  localparam int NREP = 2;
`else
  localparam int NREP = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  rx_rdy = 1'b0;
  logic [7:0]            rx_byte = 8'h00;
  logic                  tx_rdy;
  logic [7:0]            tx_byte;
  logic                  tx_busy = 1'b0;
  logic                  tx_done = 1'b0;
  logic                  reg_wr;
  logic [ADDR_W-1:0]     reg_addr;
  logic [7:0]            reg_wdata;
  logic [NUM_REGS*8-1:0] regs;
  logic                  busy;
  logic                  err;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned tx_cnt = 0;
  int unsigned wr_cnt = 0;
  int unsigned err_cnt = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mdl [NUM_REGS];

  uart_cmd_responder #(
    .NUM_REGS     (NUM_REGS),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rx_byte_rdy (rx_rdy),
    .i_rx_byte     (rx_byte),
    .o_tx_byte_rdy (tx_rdy),
    .o_tx_byte     (tx_byte),
    .i_tx_busy     (tx_busy),
    .i_tx_done     (tx_done),
    .o_reg_wr      (reg_wr),
    .o_reg_addr    (reg_addr),
    .o_reg_wdata   (reg_wdata),
    .o_regs        (regs),
    .o_busy        (busy),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  // Strobe counters sampled mid-cycle
  always @(negedge clk) begin
    if (tx_rdy === 1'b1) tx_cnt++;
    if (reg_wr === 1'b1) wr_cnt++;
    if (err === 1'b1)    err_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_byte = b;
    tick();
    rx_rdy  = 1'b0;
  endtask

  function automatic logic [NUM_REGS*8-1:0] mdl_flat();
    logic [NUM_REGS*8-1:0] f;
    for (int k = 0; k < int'(NUM_REGS); k++) f[8*k +: 8] = mdl[k];
    return f;
  endfunction

  task automatic push_reply(input logic [7:0] b);
    exp_q.push_back(b);
    if (NREP == 2) exp_q.push_back(b ^ 8'hFF);
  endtask

  task automatic catch_reply(input string tag);
    bit seen = 1'b0;
    logic [7:0] e;
    for (int i = 0; i < 64; i++) begin
      if (tx_rdy === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_strobe"}, 128'(seen), 128'(1));
    if (seen) begin
      check({tag, "_sb_nonempty"}, 128'(exp_q.size() > 0), 128'(1));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check({tag, "_byte"}, 128'(tx_byte), 128'(e));
      check({tag, "_busy"}, 128'(busy), 128'(1));
    end
  endtask

  task automatic finish_tx(input string tag);
    logic [7:0] b;
    b = tx_byte;
    tick();
    check({tag, "_one_cycle"}, 128'(tx_rdy), 128'(0));
    tx_busy = 1'b1;
    tick();
    tick();
    check({tag, "_hold"}, 128'(tx_byte), 128'(b));
    tx_busy = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic expect_replies(input string tag);
    for (int k = 0; k < NREP; k++) begin
      catch_reply(tag);
      finish_tx(tag);
      check({tag, "_busy_after"}, 128'(busy), 128'(k < NREP - 1));
    end
  endtask

  initial begin
    int unsigned c_tx, c_wr, c_err, n;
    bit got;

    for (int k = 0; k < int'(NUM_REGS); k++) mdl[k] = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_tx_byte", 128'(tx_byte), 128'(0));
    check("rst_regs", 128'(regs), 128'(0));
    check("rst_addr_data", 128'({reg_addr, reg_wdata}), 128'(0));
    check("rst_strobes", 128'({tx_rdy, reg_wr, err}), 128'(0));
    rst_n = 1'b1;
    tick();

    // Write then read back
    push_reply(8'h4B);
    send_byte(8'h57);
    check("wr_busy", 128'(busy), 128'(1));
    send_byte(8'h03);
    send_byte(8'hA5);
    mdl[3] = 8'hA5;
    check("wr_strobe", 128'(reg_wr), 128'(1));
    check("wr_addr", 128'(reg_addr), 128'(3));
    check("wr_data", 128'(reg_wdata), 128'(8'hA5));
    check("wr_regs", 128'(regs), 128'(mdl_flat()));
    check("wr_latency", 128'(tx_rdy), 128'(1));
    expect_replies("wr_k");
    push_reply(8'hA5);
    send_byte(8'h52);
    send_byte(8'h03);
    check("rd_latency", 128'(tx_rdy), 128'(1));
    expect_replies("rd3");

    // Bad address on write
    c_wr = wr_cnt; c_err = err_cnt;
    push_reply(8'h45);
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h11);
    expect_replies("badaddr");
    check("badaddr_no_wr", 128'(wr_cnt), 128'(c_wr));
    check("badaddr_err", 128'(err_cnt), 128'(c_err + 1));
    check("badaddr_regs", 128'(regs), 128'(mdl_flat()));

    // Bad opcode
    push_reply(8'h3F);
    send_byte(8'h41);
    check("badop_err", 128'(err), 128'(1));
    expect_replies("badop");

    // Inter-byte timeout
    c_tx = tx_cnt; c_wr = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h02);
    got = 1'b0; n = 0;
    for (int i = 0; i < int'(TIMEOUT_CLKS) + 20; i++) begin
      if (err === 1'b1) begin
        got = 1'b1;
        n = i;
        break;
      end
      tick();
    end
    check("to_err_seen", 128'(got), 128'(1));
    check("to_err_cycle", 128'(n), 128'(TIMEOUT_CLKS));
    tick();
    check("to_idle", 128'(busy), 128'(0));
    check("to_no_reply", 128'(tx_cnt), 128'(c_tx));
    check("to_no_wr", 128'(wr_cnt), 128'(c_wr));
    push_reply(8'h00);
    send_byte(8'h52);
    send_byte(8'h02);
    expect_replies("to_rd2");

    // Data byte arriving in the expiry cycle wins
    c_err = err_cnt;
    send_byte(8'h57);
    send_byte(8'h04);
    repeat (TIMEOUT_CLKS - 1) tick();
    push_reply(8'h4B);
    send_byte(8'h77);
    mdl[4] = 8'h77;
    check("race_wr", 128'(reg_wr), 128'(1));
    expect_replies("race");
    check("race_no_err", 128'(err_cnt), 128'(c_err));
    check("race_regs", 128'(regs), 128'(mdl_flat()));

    // Busy handshake and dropped bytes
    c_tx = tx_cnt;
    tx_busy = 1'b1;
    push_reply(8'hA5);
    send_byte(8'h52);
    send_byte(8'h03);
    repeat (3) tick();
    send_byte(8'h57);
    tick();
    check("busy_held", 128'(tx_cnt), 128'(c_tx));
    tx_busy = 1'b0;
    tick();
    check("busy_release", 128'(tx_rdy), 128'(1));
    catch_reply("busy");
    send_byte(8'h52);
    send_byte(8'h00);
    finish_tx("busy");
    for (int k = 1; k < NREP; k++) begin
      catch_reply("busy_ck");
      finish_tx("busy_ck");
    end
    repeat (3) tick();
    check("busy_one_strobe", 128'(tx_cnt), 128'(c_tx + NREP));
    check("drop_idle", 128'(busy), 128'(0));

    // Spurious done in IDLE
    c_tx = tx_cnt;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (2) tick();
    check("spur_done", 128'({busy, 32'(tx_cnt)}), 128'({1'b0, 32'(c_tx)}));

    // Register holding 0x5A reads back (complement follows when enabled)
    push_reply(8'h4B);
    send_byte(8'h57);
    send_byte(8'h06);
    send_byte(8'h5A);
    mdl[6] = 8'h5A;
    expect_replies("wr6");
    push_reply(8'h5A);
    send_byte(8'h52);
    send_byte(8'h06);
    expect_replies("rd6");

    // Reset mid-frame
    send_byte(8'h57);
    send_byte(8'h05);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", 128'(busy), 128'(0));
    check("mrst_regs", 128'(regs), 128'(0));
    check("mrst_outs", 128'({tx_byte, reg_addr, reg_wdata, tx_rdy, reg_wr, err}), 128'(0));
    for (int k = 0; k < int'(NUM_REGS); k++) mdl[k] = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    push_reply(8'h00);
    send_byte(8'h52);
    send_byte(8'h03);
    expect_replies("post_rst");

    check("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
